ahb_lite_master_if: RTL
=======================

// Module: ahb_lite_master_if
// PURPOSE
//  AHB-Lite initiator: turns a simple valid/ready command stream into single (non-burst) AHB transfers.
//  Returns one response per command, carrying read data and error status.
//  Sits at the master end of the bus. It consumes the HRDATA/HRESP/HREADY returned by the slave-to-master mux.
//  It drives HADDR/HTRANS/HWRITE/HSIZE/HWDATA into the address decoder and slaves.
// PARAMETERS
//  ADDR_W          32   address width
//  DATA_W          32   data bus width
//  TIMEOUT_CYCLES  256  consecutive wait cycles before abort (used only with AHB_MST_TIMEOUT_EN)
// PORTS
//  HCLK         in   1       bus clock
//  HRESETn      in   1       reset, asynchronous, active-low; clock HCLK
//  cmd_valid    in   1       command offered
//  cmd_ready    out  1       command accepted on edge where cmd_valid&cmd_ready
//  cmd_write    in   1       1=write, 0=read
//  cmd_addr     in   ADDR_W  byte address; caller guarantees alignment to cmd_size
//  cmd_size     in   3       HSIZE encoding (0=byte,1=half,2=word)
//  cmd_wdata    in   DATA_W  write data, already lane-positioned
//  rsp_valid    out  1       one-cycle response pulse
//  rsp_rdata    out  DATA_W  read data (0 for writes)
//  rsp_err      out  1       slave returned ERROR (or timeout)
//  rsp_timeout  out  1       response is a timeout abort (0 without macro)
//  bus_hung     out  1       sticky: timeout occurred, block halted (0 without macro)
//  HADDR        out  ADDR_W  AHB address
//  HTRANS       out  2       IDLE=2'b00 / NONSEQ=2'b10 only
//  HWRITE       out  1       AHB write
//  HSIZE        out  3       AHB size
//  HBURST       out  3       constant 3'b000 (SINGLE)
//  HPROT        out  4       constant 4'b0011
//  HWDATA       out  DATA_W  write data, valid in data phase
//  HRDATA       in   DATA_W  read data from slave-to-master mux
//  HRESP        in   1       0=OKAY, 1=ERROR (mux HRESP[0])
//  HREADY       in   1       global HREADY from slave-to-master mux
// BEHAVIOUR
//  Pipeline:
//  - Two register stages: address phase AP (valid, addr, write, size, wdata) and data phase DP (valid, write, wdata).
//  - cmd_ready = !bus_hung & (!AP.valid | HREADY).
//  - Edge with HREADY=1: DP<=AP; AP<=accepted command, else AP.valid<=0.
//  - Edge with HREADY=0: DP held. AP is held, or loaded if empty and a command is accepted (IDLE->NONSEQ in a wait state is legal).
//  Bus outputs:
//  - HTRANS = NONSEQ iff AP.valid, else IDLE.
//  - HADDR/HWRITE/HSIZE driven from AP, held stable while HREADY=0.
//  - HWDATA driven from DP.wdata.
//  Response:
//  - Edge with DP.valid & HREADY=1 -> next cycle rsp_valid=1 for one cycle.
//  - rsp_rdata = registered HRDATA (reads); rsp_err = registered HRESP.
//  - Latency: command accepted at edge N -> address phase N..N+1 -> rsp_valid in cycle N+2 with zero waits.
//  - Each wait state adds 1 cycle. Responses are always in command order.
//  - Back-to-back commands give a sustained throughput of 1 per cycle.
//  ERROR (two-cycle):
//  - First cycle (HRESP=1, HREADY=0): HTRANS forced IDLE combinationally; AP is not dropped.
//  - Second cycle (HRESP=1, HREADY=1): AP is re-presented as NONSEQ and proceeds normally.
//  - Errored command gets rsp_err=1. There is no retry of the errored transfer itself.
//  Reset (asynchronous, incl. mid-transfer):
//  - AP.valid=DP.valid=0, HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0.
//  - rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, bus_hung=0.
//  - cmd_ready=1 from first cycle after release.
//  - In-flight commands are discarded with no response.
// CONFIGURATION
//  AHB_MST_TIMEOUT_EN defined:
//  - Wait counter increments each cycle with DP.valid & HREADY=0; clears on HREADY=1.
//  - On reaching TIMEOUT_CYCLES: one rsp_valid with rsp_err=1, rsp_timeout=1; bus_hung set (sticky until reset).
//  - While bus_hung: cmd_ready=0, HTRANS=IDLE, AP/DP cleared, no further responses.
//  AHB_MST_TIMEOUT_EN undefined:
//  - No counter; rsp_timeout and bus_hung tied 0; the block waits indefinitely.
// TESTING
//  1. Write 0x0000_0010 data 0xA5A5_0001 size 2, HREADY=1 -> NONSEQ cycle 1, HWDATA=0xA5A5_0001 cycle 2, rsp_valid cycle 3 err=0.
//  2. Reads 0x0,0x4,0x8 back-to-back, slave returns 0x11,0x22,0x33 -> NONSEQ 3 consecutive cycles; rsp_rdata 0x11,0x22,0x33 in order.
//  3. Read 0x0 then write 0x4, HREADY low 3 cycles in first data phase -> HADDR=0x4 held 4 cycles, cmd_ready=0, rsp 3 cycles late.
//  4. Read 0x100 gets ERROR while read 0x104 is pending -> HTRANS=IDLE in 1st error cycle; rsp_err=1 for 0x100; 0x104 completes err=0.
//  5. Assert HRESETn=0 during a wait state with AP and DP valid -> outputs at reset values immediately; no rsp_valid after release.
//  6. With AHB_MST_TIMEOUT_EN, TIMEOUT_CYCLES=8, HREADY held low -> rsp_err=1, rsp_timeout=1 after 8 waits; bus_hung=1, cmd_ready=0 until reset.

Source files
------------

// File: rtl/ahb_lite_master_if.sv
// AHB-Lite initiator: turns a valid/ready command stream into single NONSEQ transfers, one response per command.
// Optional bus-hang watchdog is built when AHB_MST_TIMEOUT_EN is defined.
module ahb_lite_master_if #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              bus_hung,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HRESP,
  input  logic              HREADY
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic              ap_valid_q, ap_valid_d;
  logic [ADDR_W-1:0] ap_addr_q, ap_addr_d;
  logic              ap_write_q, ap_write_d;
  logic [2:0]        ap_size_q, ap_size_d;
  logic [DATA_W-1:0] ap_wdata_q, ap_wdata_d;
  logic              dp_valid_q, dp_valid_d;
  logic              dp_write_q, dp_write_d;
  logic [DATA_W-1:0] dp_wdata_q, dp_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              bus_hung_q, bus_hung_d;
  logic              accept;
  logic              timeout_hit;

`ifdef AHB_MST_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (HREADY)          wait_cnt_d = '0;
    else if (dp_valid_q) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  // Fires on the edge that closes the TIMEOUT_CYCLES-th consecutive wait state.
  assign timeout_hit = dp_valid_q & ~HREADY & ~bus_hung_q &
                       (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) wait_cnt_q <= '0;
    else          wait_cnt_q <= wait_cnt_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg  = ^TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  assign cmd_ready = ~bus_hung_q & (~ap_valid_q | HREADY);
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    ap_valid_d    = ap_valid_q;
    ap_addr_d     = ap_addr_q;
    ap_write_d    = ap_write_q;
    ap_size_d     = ap_size_q;
    ap_wdata_d    = ap_wdata_q;
    dp_valid_d    = dp_valid_q;
    dp_write_d    = dp_write_q;
    dp_wdata_d    = dp_wdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    bus_hung_d    = bus_hung_q;

    if (HREADY) begin
      dp_valid_d = ap_valid_q;
      dp_write_d = ap_write_q;
      dp_wdata_d = ap_wdata_q;
      ap_valid_d = 1'b0;
    end

    // With HREADY low accept is only possible into an empty AP.
    if (accept) begin
      ap_valid_d = 1'b1;
      ap_addr_d  = cmd_addr;
      ap_write_d = cmd_write;
      ap_size_d  = cmd_size;
      ap_wdata_d = cmd_wdata;
    end

    if (dp_valid_q && HREADY) begin
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = dp_write_q ? '0 : HRDATA;
      rsp_err_d     = HRESP;
      rsp_timeout_d = 1'b0;
    end

    if (timeout_hit) begin
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_err_d     = 1'b1;
      rsp_timeout_d = 1'b1;
      bus_hung_d    = 1'b1;
    end

    if (timeout_hit || bus_hung_q) begin
      ap_valid_d = 1'b0;
      dp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_valid_q    <= 1'b0;
      ap_addr_q     <= '0;
      ap_write_q    <= 1'b0;
      ap_size_q     <= 3'd0;
      ap_wdata_q    <= '0;
      dp_valid_q    <= 1'b0;
      dp_write_q    <= 1'b0;
      dp_wdata_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      bus_hung_q    <= 1'b0;
    end else begin
      ap_valid_q    <= ap_valid_d;
      ap_addr_q     <= ap_addr_d;
      ap_write_q    <= ap_write_d;
      ap_size_q     <= ap_size_d;
      ap_wdata_q    <= ap_wdata_d;
      dp_valid_q    <= dp_valid_d;
      dp_write_q    <= dp_write_d;
      dp_wdata_q    <= dp_wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      bus_hung_q    <= bus_hung_d;
    end
  end

  // First ERROR cycle must show IDLE so the pending address is not taken.
  assign HTRANS = (ap_valid_q && !(HRESP && !HREADY) && !bus_hung_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR  = ap_addr_q;
  assign HWRITE = ap_write_q;
  assign HSIZE  = ap_size_q;
  assign HWDATA = dp_wdata_q;
  assign HBURST = 3'b000;
  assign HPROT  = 4'b0011;

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign bus_hung    = bus_hung_q;

endmodule
